// File: rtl/edge_frame_sink_if.sv
// Stream bundle between sobel_core output and the frame sink: raw pixel input side
// plus the tagged valid/ready output side toward the consumer.
interface edge_frame_sink_if;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sof;
  logic       m_eol;
  logic       m_eof;

  modport slave (
    input  pixel_in, valid_in, m_ready,
    output m_data, m_valid, m_sof, m_eol, m_eof
  );

  modport master (
    output pixel_in, valid_in, m_ready,
    input  m_data, m_valid, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/edge_frame_sink.sv
// Receives the edge-magnitude pixel stream, tags each pixel with raster markers and
// queues it in a show-ahead FIFO; pixels arriving on a full FIFO are dropped and flagged.
module edge_frame_sink #(
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  edge_frame_sink_if.slave         bus,
  input  logic                     clear_ovf_i,
  output logic                     frame_done_o,
  output logic [15:0]              frame_count_o,
  output logic                     overflow_o
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          overflow_q, overflow_d;

  logic          empty, full, pop, push, drop;
  logic          x_last, y_last;
  logic          tag_sof, tag_eol, tag_eof;
  logic [10:0]   head;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop    = !empty && bus.m_ready;
  assign push   = bus.valid_in && (!full || pop);
  assign drop   = bus.valid_in && full && !pop;

  assign x_last  = (x_cnt_q == XW'(WIDTH - 1));
  assign y_last  = (y_cnt_q == YW'(HEIGHT - 1));
  assign tag_sof = (x_cnt_q == '0) && (y_cnt_q == '0);
  assign tag_eol = x_last;
  assign tag_eof = x_last && y_last;

  // Head fields are gated so that an empty FIFO presents all-zero outputs.
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? 8'h00 : head[7:0];
  assign bus.m_sof   = !empty && head[10];
  assign bus.m_eol   = !empty && head[9];
  assign bus.m_eof   = !empty && head[8];

  assign frame_done_o  = frame_done_q;
  assign frame_count_o = frame_count_q;
  assign overflow_o    = overflow_q;

  // Raster counters advance on every valid pixel, stored or dropped, to stay aligned.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (bus.valid_in) begin
      if (x_last) begin
        x_cnt_d = '0;
        y_cnt_d = y_last ? '0 : y_cnt_q + YW'(1);
      end else begin
        x_cnt_d = x_cnt_q + XW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    frame_done_d  = pop && head[8];
    frame_count_d = (pop && head[8]) ? frame_count_q + 16'd1 : frame_count_q;
    overflow_d    = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      overflow_q    <= 1'b0;
    end else begin
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {tag_sof, tag_eol, tag_eof, bus.pixel_in};
    end
  end

endmodule

// File: tb/tb_edge_frame_sink.sv
// Directed bench for edge_frame_sink on a 4x2 raster with a 16-entry FIFO.
module tb_edge_frame_sink;

  logic        clk;
  logic        rst_n;
  logic        clear_ovf;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overflow;
  int          checks;
  int          errors;

  edge_frame_sink_if bus ();

  edge_frame_sink #(
    .WIDTH      (4),
    .HEIGHT     (2),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .clear_ovf_i   (clear_ovf),
    .frame_done_o  (frame_done),
    .frame_count_o (frame_count),
    .overflow_o    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] pixel, input logic ready);
    bus.valid_in = valid;
    bus.pixel_in = pixel;
    bus.m_ready  = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clear_ovf = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();

    checkBit("rst_m_valid", bus.m_valid, 1'b0);
    checkOutput("rst_m_data", 16'(bus.m_data), 16'h0000);
    checkBit("rst_m_sof", bus.m_sof, 1'b0);
    checkBit("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_frame_count", frame_count, 16'd0);
    checkBit("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // T1: asynchronous reset in the middle of a line
    applyStimulus(1'b1, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 1'b0);
    tick();
    checkBit("t1_pre_valid", bus.m_valid, 1'b1);
    checkOutput("t1_pre_data", 16'(bus.m_data), 16'h0011);
    checkBit("t1_pre_sof", bus.m_sof, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    checkBit("t1_async_valid", bus.m_valid, 1'b0);
    checkOutput("t1_async_data", 16'(bus.m_data), 16'h0000);
    checkBit("t1_async_sof", bus.m_sof, 1'b0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tick();
    checkBit("t1_post_valid", bus.m_valid, 1'b1);
    checkOutput("t1_post_data", 16'(bus.m_data), 16'h00AA);
    checkBit("t1_post_sof", bus.m_sof, 1'b1);
    checkBit("t1_post_eol", bus.m_eol, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    // T2: one full 4x2 frame streamed straight through
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1);
      tick();
      checkBit($sformatf("t2_valid_%0d", i), bus.m_valid, 1'b1);
      checkOutput($sformatf("t2_data_%0d", i), 16'(bus.m_data), 16'(i));
      checkBit($sformatf("t2_sof_%0d", i), bus.m_sof, i == 1);
      checkBit($sformatf("t2_eol_%0d", i), bus.m_eol, (i == 4) || (i == 8));
      checkBit($sformatf("t2_eof_%0d", i), bus.m_eof, i == 8);
      checkBit($sformatf("t2_done_%0d", i), frame_done, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkBit("t2_done_pulse", frame_done, 1'b1);
    checkOutput("t2_count", frame_count, 16'd1);
    checkBit("t2_empty", bus.m_valid, 1'b0);
    tick();
    checkBit("t2_done_clear", frame_done, 1'b0);
    checkOutput("t2_count_hold", frame_count, 16'd1);

    // T3: fill under backpressure, overflow on the 17th pixel, then drain in order
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 8'(8'h10 + j), 1'b0);
      tick();
    end
    checkBit("t3_full_valid", bus.m_valid, 1'b1);
    checkBit("t3_full_ovf", overflow, 1'b0);
    checkOutput("t3_full_head", 16'(bus.m_data), 16'h0010);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    tick();
    checkBit("t3_drop_ovf", overflow, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t3_drain_data_%0d", k), 16'(bus.m_data), 16'(8'h10 + k));
      checkBit($sformatf("t3_drain_sof_%0d", k), bus.m_sof, (k % 8) == 0);
      checkBit($sformatf("t3_drain_eol_%0d", k), bus.m_eol, (k % 4) == 3);
      checkBit($sformatf("t3_drain_eof_%0d", k), bus.m_eof, (k % 8) == 7);
      tick();
    end
    checkBit("t3_drained", bus.m_valid, 1'b0);
    checkBit("t3_last_done", frame_done, 1'b1);
    checkOutput("t3_count", frame_count, 16'd3);
    checkBit("t3_ovf_sticky", overflow, 1'b1);
    clear_ovf = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    clear_ovf = 1'b0;
    checkBit("t3_ovf_cleared", overflow, 1'b0);

    // T4: push and pop together on a full FIFO
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 8'(8'h40 + j), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h99, 1'b1);
    tick();
    checkBit("t4_simul_ovf", overflow, 1'b0);
    checkBit("t4_simul_valid", bus.m_valid, 1'b1);
    checkOutput("t4_simul_head", 16'(bus.m_data), 16'h0041);
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick();
    checkBit("t4_still_full", overflow, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 15; k++) begin
      checkOutput($sformatf("t4_drain_%0d", k), 16'(bus.m_data), 16'(8'h41 + k));
      tick();
    end
    checkOutput("t4_drain_last", 16'(bus.m_data), 16'h0099);
    tick();
    checkBit("t4_drained", bus.m_valid, 1'b0);
    checkOutput("t4_count", frame_count, 16'd5);

    // T5: raster alignment across drops, and drop beats a coincident clear
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    checkBit("t5_reset_ovf", overflow, 1'b0);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 8'(8'h50 + j), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'hD0, 1'b0);
    tick();
    checkBit("t5_drop_x0", overflow, 1'b1);
    applyStimulus(1'b1, 8'hD1, 1'b0);
    tick();
    clear_ovf = 1'b1;
    applyStimulus(1'b1, 8'hD2, 1'b0);
    tick();
    clear_ovf = 1'b0;
    checkBit("t5_set_wins", overflow, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hEE, 1'b0);
    tick();
    checkBit("t5_stored_ovf", overflow, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 15; k++) begin
      checkOutput($sformatf("t5_drain_%0d", k), 16'(bus.m_data), 16'(8'h51 + k));
      tick();
    end
    checkOutput("t5_after_drop_data", 16'(bus.m_data), 16'h00EE);
    checkBit("t5_after_drop_eol", bus.m_eol, 1'b1);
    checkBit("t5_after_drop_eof", bus.m_eof, 1'b0);
    checkBit("t5_after_drop_sof", bus.m_sof, 1'b0);
    tick();
    checkBit("t5_drained", bus.m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
